// File: rtl/rom_word_loader_if.sv
// ROM write port between the word loader (master) and the SPI ROM controller (slave).
`timescale 1ns/1ps
interface rom_word_loader_if #(
    parameter int ADDR_WIDTH = 15
);
    // wr_req stays high while a word is pending. wr_addr/wr_data must hold until the cycle
    // in which wr_req && wr_ack are both high; that cycle transfers the word. wr_ack alone is ignored.
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;
    logic                  wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rom_word_loader.sv
// Packs UART bytes into 16-bit words (MSB first) and streams them through a small FIFO
// to consecutive ROM addresses, holding 'loading' until the image is committed.
`timescale 1ns/1ps
module rom_word_loader #(
    parameter int ADDR_WIDTH     = 15,
    parameter int MAX_WORDS      = 32768,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    rom_word_loader_if.master   wr,
    output logic                loading,
    output logic                load_done,
    output logic [ADDR_WIDTH:0] word_count,
    output logic                error,
    output logic [1:0]          dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]      TMO_ONE   = TMO_W'(1);
    localparam logic [ADDR_WIDTH:0]   MAX_W     = (ADDR_WIDTH + 1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0]   WC_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MAX_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  phase_q, phase_d;   // 1: high byte held, waiting for low byte
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH:0]   accepted_q, accepted_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                  error_q, error_d;
    logic                  load_done_q, load_done_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [15:0]           mem_d [FIFO_DEPTH];

    logic pop, full, push_req, push_ok, load_start, error_set;

    assign pop  = (count_q != '0) && wr.wr_ack;
    assign full = (count_q == CNT_FULL);

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        accepted_d   = accepted_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        error_d      = error_q;
        load_done_d  = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        mem_d        = mem_q;
        push_req     = 1'b0;
        push_ok      = 1'b0;
        load_start   = 1'b0;
        error_set    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (rx_valid) begin
                    state_d    = S_RECV;
                    load_start = 1'b1;
                    hi_d       = rx_data;
                    phase_d    = 1'b1;
                    tmo_d      = '0;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (!phase_q) begin
                        hi_d    = rx_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        push_req = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DRAIN;
                    tmo_d   = '0;
                    // A lone high byte at end of reception is discarded.
                    if (phase_q) begin
                        phase_d   = 1'b0;
                        error_set = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_DRAIN: begin
                if (rx_valid) error_set = 1'b1;
                if ((count_q == '0) || ((count_q == CNT_ONE) && pop)) begin
                    state_d     = S_DONE;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full FIFO still takes the word when the head leaves on the same edge.
        if (push_req) begin
            if (accepted_q >= MAX_W)   error_set = 1'b1;
            else if (full && !pop)     error_set = 1'b1;
            else                       push_ok   = 1'b1;
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = {hi_q, rx_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d = count_q + (push_ok ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);

        if (load_start) begin
            accepted_d   = '0;
            addr_d       = '0;
            word_count_d = '0;
            error_d      = 1'b0;
        end else begin
            if (error_set) error_d = 1'b1;
            if (push_ok) accepted_d = accepted_q + WC_ONE;
            if (pop) begin
                word_count_d = word_count_q + WC_ONE;
                if (addr_q != ADDR_LAST) addr_d = addr_q + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            accepted_q   <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
            load_done_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mem_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            accepted_q   <= accepted_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            error_q      <= error_d;
            load_done_q  <= load_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    assign wr.wr_req  = (count_q != '0);
    assign wr.wr_addr = addr_q;
    assign wr.wr_data = mem_q[rd_ptr_q];
    assign loading    = (state_q == S_RECV) || (state_q == S_DRAIN);
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign error      = error_q;
    assign dbg_state  = state_q;
endmodule
